// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: request opcode encoding, FSM state
// encoding and the alignment-check helper used when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_LH  = 3'd1,
      OP_LHU = 3'd2,
      OP_LB  = 3'd3,
      OP_LBU = 3'd4,
      OP_SW  = 3'd5,
      OP_SH  = 3'd6,
      OP_SB  = 3'd7
   } lsu_op_e;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_RSP  = 2'd3;

   function automatic logic op_is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
      logic mis;
      case (op)
         OP_LW, OP_SW:         mis = (addr_lo != 2'b00);
         OP_LH, OP_LHU, OP_SH: mis = addr_lo[0];
         default:              mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane logic: merges store data into a memory word and extracts
// sign/zero-extended load results. Halfwords are selected by addr[1] only.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] merged,
   output logic [31:0] rdata
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // lane selection from the addressed word
   always_comb begin
      case (addr_lo)
         2'd0:    byte_s = word[7:0];
         2'd1:    byte_s = word[15:8];
         2'd2:    byte_s = word[23:16];
         2'd3:    byte_s = word[31:24];
         default: byte_s = 8'd0;
      endcase
      if (addr_lo[1]) begin
         half_s = word[31:16];
      end else begin
         half_s = word[15:0];
      end
   end

   // store merge: untouched lanes keep the captured word
   always_comb begin
      merged = word;
      case (op)
         OP_SW: merged = wdata;
         OP_SH: begin
            if (addr_lo[1]) begin
               merged[31:16] = wdata[15:0];
            end else begin
               merged[15:0] = wdata[15:0];
            end
         end
         OP_SB: begin
            case (addr_lo)
               2'd0:    merged[7:0]   = wdata[7:0];
               2'd1:    merged[15:8]  = wdata[7:0];
               2'd2:    merged[23:16] = wdata[7:0];
               2'd3:    merged[31:24] = wdata[7:0];
               default: merged        = word;
            endcase
         end
         default: merged = word;
      endcase
   end

   // load extraction with extension
   always_comb begin
      case (op)
         OP_LW:   rdata = word;
         OP_LH:   rdata = {{16{half_s[15]}}, half_s};
         OP_LHU:  rdata = {16'd0, half_s};
         OP_LB:   rdata = {{24{byte_s[7]}}, byte_s};
         OP_LBU:  rdata = {24'd0, byte_s};
         default: rdata = 32'd0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit in front of a word-wide data memory (IDLE/RD/WR/RSP).
// Define LSU_MISALIGN_TRAP_EN to fault misaligned word/halfword accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_WORDS = 256
) (
   input  logic        clk,
   input  logic        SYS_reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] DMEM_address,
   output logic [31:0] DMEM_data_in,
   output logic        DMEM_mem_write,
   output logic        DMEM_mem_read,
   input  logic [31:0] DMEM_data_out
);

   localparam logic [29:0] ADDR_LIMIT = 30'(ADDR_WORDS);

   logic [1:0]  state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic [31:0] wdata_q, wdata_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] dmem_addr_q, dmem_addr_d;
   logic [31:0] dmem_wdata_q, dmem_wdata_d;
   logic        dmem_wr_q, dmem_wr_d;
   logic        dmem_rd_q, dmem_rd_d;

   logic        misalign_s;
   logic        range_err_s;
   logic        fault_s;
   logic [31:0] merged_s;
   logic [31:0] load_s;

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign_s = op_is_misaligned(req_op, req_addr[1:0]);
`else
   assign misalign_s = 1'b0;
`endif

   assign range_err_s = (req_addr[31:2] >= ADDR_LIMIT);
   assign fault_s     = range_err_s | misalign_s;

   lsu_lane u_lane (
      .op      (op_q),
      .addr_lo (addr_lo_q),
      .word    (DMEM_data_out),
      .wdata   (wdata_q),
      .merged  (merged_s),
      .rdata   (load_s)
   );

   // next-state and next-output logic; outputs are registered from *_d
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_lo_d    = addr_lo_q;
      wdata_d      = wdata_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      dmem_wr_d    = 1'b0;
      dmem_rd_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d      = req_op;
               addr_lo_d = req_addr[1:0];
               wdata_d   = req_wdata;
               if (fault_s) begin
                  state_d     = ST_RSP;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = 32'd0;
                  rsp_err_d   = 1'b1;
               end else if (req_op == OP_SW) begin
                  state_d      = ST_WR;
                  dmem_addr_d  = {2'b00, req_addr[31:2]};
                  dmem_wdata_d = req_wdata;
                  dmem_wr_d    = 1'b1;
               end else begin
                  state_d     = ST_RD;
                  dmem_addr_d = {2'b00, req_addr[31:2]};
                  dmem_rd_d   = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD: begin
            // read word is sampled here; sub-word stores merge it before writing back
            if ((op_q == OP_SH) || (op_q == OP_SB)) begin
               state_d      = ST_WR;
               dmem_wdata_d = merged_s;
               dmem_wr_d    = 1'b1;
            end else begin
               state_d     = ST_RSP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = load_s;
               rsp_err_d   = 1'b0;
            end
         end
         ST_WR: begin
            state_d     = ST_RSP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b0;
         end
         ST_RSP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = 32'd0;
               rsp_err_d   = 1'b0;
            end else begin
               state_d = ST_RSP;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b0;
         end
      endcase
      req_ready_d = (state_d == ST_IDLE);
   end

   // state and output registers; reset drops strobes asynchronously
   always_ff @(posedge clk or posedge SYS_reset) begin
      if (SYS_reset) begin
         state_q      <= ST_IDLE;
         op_q         <= 3'd0;
         addr_lo_q    <= 2'd0;
         wdata_q      <= 32'd0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= 32'd0;
         rsp_err_q    <= 1'b0;
         dmem_addr_q  <= 32'd0;
         dmem_wdata_q <= 32'd0;
         dmem_wr_q    <= 1'b0;
         dmem_rd_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_lo_q    <= addr_lo_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         dmem_wr_q    <= dmem_wr_d;
         dmem_rd_q    <= dmem_rd_d;
      end
   end

   assign req_ready      = req_ready_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign rsp_err        = rsp_err_q;
   assign DMEM_address   = dmem_addr_q;
   assign DMEM_data_in   = dmem_wdata_q;
   assign DMEM_mem_write = dmem_wr_q;
   assign DMEM_mem_read  = dmem_rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of requests with hand-computed results,
// plus sequences for reset during a write and requests arriving while busy.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        SYS_reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] DMEM_address;
   logic [31:0] DMEM_data_in;
   logic        DMEM_mem_write;
   logic        DMEM_mem_read;
   logic [31:0] DMEM_data_out;

   logic [31:0] mem [0:255];
   bit          mem_init_done = 1'b0;
   int          writes_seen = 0;
   int          reads_seen = 0;
   int          overlap_seen = 0;
   logic [31:0] last_waddr = 32'd0;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          hold;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          reads;
      int          writes;
   } vec_t;

   vec_t vecs [0:31];
   int   n_vec = 0;

   load_store_unit #(.ADDR_WORDS(256)) dut (
      .clk            (clk),
      .SYS_reset      (SYS_reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_op         (req_op),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_rdata      (rsp_rdata),
      .rsp_err        (rsp_err),
      .DMEM_address   (DMEM_address),
      .DMEM_data_in   (DMEM_data_in),
      .DMEM_mem_write (DMEM_mem_write),
      .DMEM_mem_read  (DMEM_mem_read),
      .DMEM_data_out  (DMEM_data_out)
   );

   always #5 clk = ~clk;

   assign DMEM_data_out = (DMEM_address < 32'd256) ? mem[DMEM_address[7:0]] : 32'd0;

   // memory model: commits on the falling edge, and counts strobes seen there
   always @(negedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
         mem_init_done <= 1'b1;
      end
      if (DMEM_mem_write && DMEM_mem_read) overlap_seen <= overlap_seen + 1;
      if (DMEM_mem_read) reads_seen <= reads_seen + 1;
      if (DMEM_mem_write) begin
         writes_seen <= writes_seen + 1;
         last_waddr  <= DMEM_address;
         if (DMEM_address < 32'd256) mem[DMEM_address[7:0]] <= DMEM_data_in;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input int hold, input logic [31:0] rdata, input logic err,
                      input int lat, input int reads, input int writes);
      vecs[n_vec] = '{op, addr, wdata, hold, rdata, err, lat, reads, writes};
      n_vec++;
   endtask

   // issue one request, measure latency, optionally stall the response, then consume it
   task automatic run_req(input string name, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
      @(negedge clk);
      check({name, " ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rd = rsp_rdata;
      er = rsp_err;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check({name, " held valid"}, {31'd0, rsp_valid}, 32'd1);
         check({name, " held rdata"}, rsp_rdata, rd);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check({name, " back idle"}, {31'd0, req_ready}, 32'd1);
      check({name, " valid drop"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          r0;
      int          w0;
      int          waited;
      logic [31:0] word4;
      string       nm;

      add(OP_SW,  32'h10,  32'hDEADBEEF, 0, 32'h0,        1'b0, 2, 0, 1);
      add(OP_LW,  32'h10,  32'h0,        2, 32'hDEADBEEF, 1'b0, 2, 1, 0);
      add(OP_SB,  32'h11,  32'h00000055, 0, 32'h0,        1'b0, 3, 1, 1);
      add(OP_LW,  32'h10,  32'h0,        0, 32'hDEAD55EF, 1'b0, 2, 1, 0);
      add(OP_SW,  32'h10,  32'h80FF7F01, 0, 32'h0,        1'b0, 2, 0, 1);
      add(OP_LB,  32'h12,  32'h0,        0, 32'hFFFFFFFF, 1'b0, 2, 1, 0);
      add(OP_LBU, 32'h13,  32'h0,        0, 32'h00000080, 1'b0, 2, 1, 0);
      add(OP_LH,  32'h10,  32'h0,        0, 32'h00007F01, 1'b0, 2, 1, 0);
      add(OP_LHU, 32'h12,  32'h0,        0, 32'h000080FF, 1'b0, 2, 1, 0);
      add(OP_LH,  32'h12,  32'h0,        1, 32'hFFFF80FF, 1'b0, 2, 1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      add(OP_LW,  32'h11,  32'h0,        0, 32'h0,        1'b1, 1, 0, 0);
      add(OP_LHU, 32'h11,  32'h0,        0, 32'h0,        1'b1, 1, 0, 0);
`else
      add(OP_LW,  32'h11,  32'h0,        0, 32'h80FF7F01, 1'b0, 2, 1, 0);
      add(OP_LHU, 32'h11,  32'h0,        0, 32'h00007F01, 1'b0, 2, 1, 0);
`endif
      add(OP_SW,  32'h400, 32'h55AA55AA, 1, 32'h0,        1'b1, 1, 0, 0);
      add(OP_SW,  32'h3FC, 32'hA5A50F0F, 0, 32'h0,        1'b0, 2, 0, 1);
      add(OP_LB,  32'h3FF, 32'h0,        0, 32'hFFFFFFA5, 1'b0, 2, 1, 0);
      add(OP_LBU, 32'h400, 32'h0,        0, 32'h0,        1'b1, 1, 0, 0);
      add(OP_SH,  32'h12,  32'h00001234, 0, 32'h0,        1'b0, 3, 1, 1);
      add(OP_SB,  32'h13,  32'h000000AA, 0, 32'h0,        1'b0, 3, 1, 1);
      add(OP_LW,  32'h10,  32'h0,        1, 32'hAA347F01, 1'b0, 2, 1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      add(OP_SH,  32'h13,  32'h0000BEEF, 0, 32'h0,        1'b1, 1, 0, 0);
      add(OP_LW,  32'h10,  32'h0,        0, 32'hAA347F01, 1'b0, 2, 1, 0);
      word4 = 32'hAA347F01;
`else
      add(OP_SH,  32'h13,  32'h0000BEEF, 0, 32'h0,        1'b0, 3, 1, 1);
      add(OP_LW,  32'h10,  32'h0,        0, 32'hBEEF7F01, 1'b0, 2, 1, 0);
      word4 = 32'hBEEF7F01;
`endif

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      SYS_reset = 1'b0;
      @(posedge clk);
      #1;
      check("rst req_ready", {31'd0, req_ready}, 32'd1);
      check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst rsp_rdata", rsp_rdata, 32'd0);
      check("rst rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst dmem_write", {31'd0, DMEM_mem_write}, 32'd0);
      check("rst dmem_read", {31'd0, DMEM_mem_read}, 32'd0);
      check("rst dmem_addr", DMEM_address, 32'd0);
      check("rst dmem_data_in", DMEM_data_in, 32'd0);

      for (int i = 0; i < n_vec; i++) begin
         nm = $sformatf("v%0d", i);
         r0 = reads_seen;
         w0 = writes_seen;
         run_req(nm, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].hold, rd, er, lat);
         check({nm, " rdata"}, rd, vecs[i].rdata);
         check({nm, " err"}, {31'd0, er}, {31'd0, vecs[i].err});
         check({nm, " latency"}, lat, vecs[i].lat);
         check({nm, " read strobes"}, reads_seen - r0, vecs[i].reads);
         check({nm, " write strobes"}, writes_seen - w0, vecs[i].writes);
         if (vecs[i].writes > 0) check({nm, " write word"}, last_waddr, {2'b00, vecs[i].addr[31:2]});
      end
      check("mem word4", mem[4], word4);
      check("mem word255", mem[255], 32'hA5A50F0F);

      // reset asserted while an SB is in its write cycle
      w0 = writes_seen;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_SB;
      req_addr  = 32'h10;
      req_wdata = 32'h00000077;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("rstwr in RD", {31'd0, DMEM_mem_read}, 32'd1);
      @(posedge clk);
      #1;
      check("rstwr in WR", {31'd0, DMEM_mem_write}, 32'd1);
      SYS_reset = 1'b1;
      #1;
      check("rstwr strobe drop", {31'd0, DMEM_mem_write}, 32'd0);
      check("rstwr rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rstwr idle", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      SYS_reset = 1'b0;
      @(posedge clk);
      #1;
      check("rstwr no write", writes_seen - w0, 32'd0);
      check("rstwr rsp_valid after", {31'd0, rsp_valid}, 32'd0);
      run_req("rstwr reload", OP_LW, 32'h10, 32'h0, 0, rd, er, lat);
      check("rstwr word unchanged", rd, word4);

      // request held/changed while busy must be ignored
      w0 = writes_seen;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_SW;
      req_addr  = 32'h20;
      req_wdata = 32'h11111111;
      @(posedge clk);
      #1;
      req_addr  = 32'h24;
      req_wdata = 32'h22222222;
      waited = 1;
      while (!rsp_valid && waited < 10) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check("busy latency", waited, 32'd2);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      check("busy writes", writes_seen - w0, 32'd1);
      check("busy word8", mem[8], 32'h11111111);
      check("busy word9", mem[9], 32'h00000000);
      check("strobe overlap", overlap_seen, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
